// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Shared widths, types and FSM encoding for the BCD digit multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int BCD_DIGIT_W  = 4;
    localparam int MUL_A_DIGITS = 4;
    localparam int MUL_R_DIGITS = 5;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bcd_mul_state_e;

    function automatic logic is_bcd_digit(input bcd_digit_t d);
        return (d <= bcd_digit_t'(9));
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
// Module : bcd_digit_add
// One-digit BCD adder: binary sum with +6 correction when the sum exceeds 9.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [BCD_DIGIT_W:0] bin_sum;
    logic [BCD_DIGIT_W:0] adj_sum;

    always_comb begin
        bin_sum = {1'b0, x} + {1'b0, y} + {{BCD_DIGIT_W{1'b0}}, cin};
        adj_sum = bin_sum + (BCD_DIGIT_W+1)'(6);
        cout    = (bin_sum > (BCD_DIGIT_W+1)'(9));
        s       = cout ? adj_sum[BCD_DIGIT_W-1:0] : bin_sum[BCD_DIGIT_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/bcd_mul_digit.sv
// ============================================================================
// Module : bcd_mul_digit
// 4-digit x 1-digit BCD multiplier by repeated addition, one add per clock.
// Optional input checking and err output enabled by BCD_MUL_ERR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_mul_digit
    import bcd_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [MUL_A_DIGITS*BCD_DIGIT_W-1:0]  a,
    input  bcd_digit_t                           b,
    output logic                                 busy,
    output logic                                 done,
`ifdef BCD_MUL_ERR_EN
    output logic                                 err,
`endif
    output logic [MUL_R_DIGITS*BCD_DIGIT_W-1:0]  result
);

    localparam int R_W = MUL_R_DIGITS * BCD_DIGIT_W;
    localparam int A_W = MUL_A_DIGITS * BCD_DIGIT_W;

    bcd_mul_state_e   state_q;
    logic [A_W-1:0]   a_q;
    bcd_digit_t       cnt_q;
    logic [R_W-1:0]   acc_q;
    logic [R_W-1:0]   acc_d;
    logic [R_W-1:0]   result_q;
    logic             busy_q;
    logic             done_q;

    logic [R_W-1:0]          addend;
    logic [MUL_R_DIGITS-1:0] carry;
    logic                    carry_unused;

    assign addend   = {{(R_W-A_W){1'b0}}, a_q};
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < MUL_R_DIGITS; i++) begin : g_digit
        if (i == MUL_R_DIGITS-1) begin : g_last
            // Product never exceeds 89991, so the top carry is always zero.
            bcd_digit_add u_add (
                .x    (acc_q [i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .y    (addend[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .cin  (carry[i]),
                .s    (acc_d [i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .cout (carry_unused)
            );
        end else begin : g_mid
            bcd_digit_add u_add (
                .x    (acc_q [i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .y    (addend[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .cin  (carry[i]),
                .s    (acc_d [i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .cout (carry[i+1])
            );
        end
    end

`ifdef BCD_MUL_ERR_EN
    logic err_q;
    logic in_bad;

    always_comb begin
        in_bad = !is_bcd_digit(b);
        for (int k = 0; k < MUL_A_DIGITS; k++) begin
            if (!is_bcd_digit(a[k*BCD_DIGIT_W +: BCD_DIGIT_W])) in_bad = 1'b1;
        end
    end

    assign err = err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BCD_MUL_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
`ifdef BCD_MUL_ERR_EN
                        // Zero count makes RUN publish the cleared accumulator at once.
                        cnt_q   <= in_bad ? '0 : b;
                        err_q   <= in_bad;
`else
                        cnt_q   <= b;
`endif
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

`default_nettype wire
